wb_retire_unit: RTL and testbench

Writeback and retirement end of the MEM/WB pipeline interface. It consumes the MEM/WB register outputs and performs the following:
- selects and extends the writeback data;
- commits it to the 32x32 integer register file;
- serves the two decode-stage read ports;
- counts retired instructions and taken jumps;
- latches the ecall display value;
- runs the halt state machine driven by the pause flag.

It sits after the MEM/WB register and feeds the ID stage and the forwarding unit.

---
 rtl/wb_pkg.sv | 25 ++
 rtl/wb_regfile.sv | 68 ++++++
 rtl/wb_retire_unit.sv | 149 ++++++++++++++
 tb/tb_wb_retire_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared definitions for the writeback / retirement slice:
//   - ECALL_INSTR : encoding that identifies an ecall for the display latch
//   - REG_ADDR_W  : register address width
//   - HALF_EXT_W  : number of sign bits added when widening a halfword load
//   - wb_state_t  : retirement state (RUN / HALTED)
//   - sext_half() : halfword sign-extension helper
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam logic [31:0] ECALL_INSTR = 32'h0000_0073;
  localparam int          REG_ADDR_W  = 5;
  localparam int          HALF_EXT_W  = 16;

  typedef logic [0:0] wb_state_t;
  localparam wb_state_t RUN    = 1'b0;
  localparam wb_state_t HALTED = 1'b1;

  // Widen a 16-bit load value to 32 bits, replicating its sign bit.
  function automatic logic [31:0] sext_half(input logic [15:0] half_val);
    return {{HALF_EXT_W{half_val[15]}}, half_val};
  endfunction

endpackage

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// NREG x 32 integer register file: one synchronous write port, two
// combinational read ports. x0 is never written and always reads zero.
// Optional macro WB_BYPASS_EN: a read whose address matches the active write
// returns the write data in the same cycle (write-through).
// Ports:
//   clk, rst             clock, synchronous active-high reset (clears all regs)
//   we_i/waddr_i/wdata_i write port
//   raddr1_i/rdata1_o    read port 1
//   raddr2_i/rdata2_o    read port 2
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int NREG = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);

  logic [31:0] mem_q [NREG];

  // Storage update: clear on reset, otherwise commit the write (x0 excluded).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port 1: zero for x0, optional same-cycle write-through.
  always_comb begin
    rdata1_o = 32'h0000_0000;
    if (raddr1_i == 5'd0) begin
      rdata1_o = 32'h0000_0000;
`ifdef WB_BYPASS_EN
    end else if (we_i && (raddr1_i == waddr_i)) begin
      rdata1_o = wdata_i;
`endif
    end else begin
      rdata1_o = mem_q[raddr1_i];
    end
  end

  // Read port 2: zero for x0, optional same-cycle write-through.
  always_comb begin
    rdata2_o = 32'h0000_0000;
    if (raddr2_i == 5'd0) begin
      rdata2_o = 32'h0000_0000;
`ifdef WB_BYPASS_EN
    end else if (we_i && (raddr2_i == waddr_i)) begin
      rdata2_o = wdata_i;
`endif
    end else begin
      rdata2_o = mem_q[raddr2_i];
    end
  end

endmodule

// File: rtl/wb_retire_unit.sv
// -----------------------------------------------------------------------------
// wb_retire_unit
// Writeback / retirement end of the MEM/WB interface. Selects and extends the
// writeback data, commits it to the register file, serves two decode read
// ports, counts retired instructions and taken jumps, latches the ecall display
// value and halts the core on a pausing instruction.
// Optional macro WB_BYPASS_EN (passed to wb_regfile): same-cycle write-through
// on the read ports.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   retire_en                MEM/WB holds a new instruction this cycle
//   pc_in, instr_in          retiring PC (diagnostic), instruction (0 = bubble)
//   mem_to_reg_in, half_in   writeback source select, halfword load
//   reg_write_in, rd_addr_in register write request and destination
//   alu_res1_in/alu_res2_in  ALU result / ecall display operand
//   dmem_out_in              load data
//   jump_in, pause_in        taken jump, halt request
//   rs1_addr/rs2_addr -> rs1_data/rs2_data  decode read ports
//   wb_we, wb_rd, wb_data    effective write (for forwarding)
//   halted, retired_cnt, jump_cnt, disp_data  status outputs
// -----------------------------------------------------------------------------
module wb_retire_unit #(
  parameter int          NREG        = 32,
  parameter int          CNT_W       = 32,
  parameter logic [31:0] ECALL_INSTR = wb_pkg::ECALL_INSTR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             retire_en,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic             mem_to_reg_in,
  input  logic             reg_write_in,
  input  logic [4:0]       rd_addr_in,
  input  logic [31:0]      alu_res1_in,
  input  logic [31:0]      alu_res2_in,
  input  logic [31:0]      dmem_out_in,
  input  logic             jump_in,
  input  logic             pause_in,
  input  logic             half_in,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [31:0]      rs1_data,
  output logic [31:0]      rs2_data,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [31:0]      wb_data,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] jump_cnt,
  output logic [31:0]      disp_data
);

  import wb_pkg::*;

  wb_state_t        state_q,   state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] jumps_q,   jumps_d;
  logic [31:0]      disp_q,    disp_d;
  logic             commit_s;
  logic             unused_s;

  // The PC travels with the instruction for debug only.
  assign unused_s = ^pc_in;

  // A stalled entry, a bubble or a halted core never retires.
  assign commit_s = retire_en & (instr_in != 32'h0000_0000) & (state_q == RUN);
  assign wb_we    = commit_s & reg_write_in & (rd_addr_in != 5'd0);
  assign wb_rd    = rd_addr_in;

  // Writeback source select; half_in only matters for loads.
  always_comb begin
    wb_data = alu_res1_in;
    if (!mem_to_reg_in) begin
      wb_data = alu_res1_in;
    end else if (half_in) begin
      wb_data = sext_half(dmem_out_in[15:0]);
    end else begin
      wb_data = dmem_out_in;
    end
  end

  // Next-state for counters, display latch and halt FSM.
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    jumps_d   = jumps_q;
    disp_d    = disp_q;
    if (commit_s) begin
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (jump_in) begin
        jumps_d = jumps_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        jumps_d = jumps_q;
      end
      // A pausing ecall halts without updating the display.
      if ((instr_in == ECALL_INSTR) && !pause_in) begin
        disp_d = alu_res2_in;
      end else begin
        disp_d = disp_q;
      end
      if (pause_in) begin
        state_d = HALTED;
      end else begin
        state_d = state_q;
      end
    end else begin
      state_d   = state_q;
      retired_d = retired_q;
      jumps_d   = jumps_q;
      disp_d    = disp_q;
    end
  end

  // State registers; reset wins over any same-cycle commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      retired_q <= {CNT_W{1'b0}};
      jumps_q   <= {CNT_W{1'b0}};
      disp_q    <= 32'h0000_0000;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      jumps_q   <= jumps_d;
      disp_q    <= disp_d;
    end
  end

  assign halted      = (state_q == HALTED);
  assign retired_cnt = retired_q;
  assign jump_cnt    = jumps_q;
  assign disp_data   = disp_q;

  wb_regfile #(
    .NREG(NREG)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we_i     (wb_we),
    .waddr_i  (rd_addr_in),
    .wdata_i  (wb_data),
    .raddr1_i (rs1_addr),
    .raddr2_i (rs2_addr),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

endmodule

// File: tb/tb_wb_retire_unit.sv
module tb_wb_retire_unit;

  localparam logic [31:0] ECALL = 32'h0000_0073;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, retire_en, mem_to_reg_in, reg_write_in, jump_in, pause_in, half_in;
  logic [31:0] pc_in, instr_in, alu_res1_in, alu_res2_in, dmem_out_in;
  logic [4:0]  rd_addr_in, rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_data, disp_data, retired_cnt, jump_cnt;
  logic        wb_we, halted;
  logic [4:0]  wb_rd;

  wb_retire_unit dut (
    .clk(clk), .rst(rst), .retire_en(retire_en), .pc_in(pc_in), .instr_in(instr_in),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in), .rd_addr_in(rd_addr_in),
    .alu_res1_in(alu_res1_in), .alu_res2_in(alu_res2_in), .dmem_out_in(dmem_out_in),
    .jump_in(jump_in), .pause_in(pause_in), .half_in(half_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .halted(halted),
    .retired_cnt(retired_cnt), .jump_cnt(jump_cnt), .disp_data(disp_data)
  );

  // Behavioural model: architectural state only.
  logic [31:0] m_regs [32];
  logic [31:0] m_ret, m_jmp, m_disp;
  logic        m_halt;
  logic [31:0] ret_bias = 32'h0;   // offset introduced by the forced counter preload
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic exp_commit();
    return retire_en && (instr_in != 32'h0) && !m_halt;
  endfunction

  function automatic logic exp_we();
    return exp_commit() && reg_write_in && (rd_addr_in != 5'd0);
  endfunction

  function automatic logic [31:0] exp_wbdata();
    if (!mem_to_reg_in) return alu_res1_in;
    if (half_in) return 32'($signed(dmem_out_in[15:0]));
    return dmem_out_in;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef WB_BYPASS_EN
    if (exp_we() && (a == rd_addr_in)) return exp_wbdata();
`endif
    return m_regs[a];
  endfunction

  // Model state update at the active edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
      m_ret  <= 32'h0;
      m_jmp  <= 32'h0;
      m_disp <= 32'h0;
      m_halt <= 1'b0;
    end else if (exp_commit()) begin
      if (exp_we()) m_regs[rd_addr_in] <= exp_wbdata();
      m_ret <= m_ret + 32'd1;
      if (jump_in) m_jmp <= m_jmp + 32'd1;
      if ((instr_in == ECALL) && !pause_in) m_disp <= alu_res2_in;
      if (pause_in) m_halt <= 1'b1;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("wb_we",     {31'b0, wb_we},  {31'b0, exp_we()});
      chk("wb_rd",     {27'b0, wb_rd},  {27'b0, rd_addr_in});
      chk("wb_data",   wb_data,         exp_wbdata());
      chk("rs1_data",  rs1_data,        exp_read(rs1_addr));
      chk("rs2_data",  rs2_data,        exp_read(rs2_addr));
      chk("halted",    {31'b0, halted}, {31'b0, m_halt});
      chk("retired",   retired_cnt,     m_ret + ret_bias);
      chk("jump_cnt",  jump_cnt,        m_jmp);
      chk("disp_data", disp_data,       m_disp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    retire_en = 1'b0; instr_in = 32'h0; pc_in = 32'h0; mem_to_reg_in = 1'b0;
    reg_write_in = 1'b0; rd_addr_in = 5'd0; alu_res1_in = 32'h0; alu_res2_in = 32'h0;
    dmem_out_in = 32'h0; jump_in = 1'b0; pause_in = 1'b0; half_in = 1'b0;
  endtask

  task automatic retire(input logic [31:0] ins, input logic rw, input logic [4:0] rd,
                        input logic [31:0] a1);
    idle();
    retire_en = 1'b1; instr_in = ins; reg_write_in = rw; rd_addr_in = rd; alu_res1_in = a1;
  endtask

  task automatic probe(input logic [4:0] a1, input logic [4:0] a2);
    idle();
    rs1_addr = a1; rs2_addr = a2;
    @(negedge clk);
  endtask

  initial begin
    idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    probe(5'd1, 5'd31);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_ret", retired_cnt, 32'h0);
    chk("rst_x31", rs2_data, 32'h0);
    tick();

    // 1: write and read back
    retire(32'h0050_0093, 1'b1, 5'd1, 32'd5);
    tick();
    probe(5'd1, 5'd0);
    chk("t1_x1", rs1_data, 32'd5);
    chk("t1_ret", retired_cnt, 32'd1);
    tick();

    // 2: halfword and word loads
    retire(32'h0001_1103, 1'b1, 5'd2, 32'h55);
    mem_to_reg_in = 1'b1; half_in = 1'b1; dmem_out_in = 32'h1234_8001;
    tick();
    probe(5'd2, 5'd0);
    chk("t2_half", rs1_data, 32'hFFFF_8001);
    tick();
    retire(32'h0001_2103, 1'b1, 5'd2, 32'h55);
    mem_to_reg_in = 1'b1; half_in = 1'b0; dmem_out_in = 32'h1234_8001;
    tick();
    probe(5'd2, 5'd0);
    chk("t2_word", rs1_data, 32'h1234_8001);
    tick();

    // 3: stall, bubble, x0
    retire(32'h0070_0193, 1'b1, 5'd3, 32'd77);
    retire_en = 1'b0;
    repeat (3) tick();
    retire(32'h0, 1'b1, 5'd3, 32'd88);
    jump_in = 1'b1; pause_in = 1'b1;
    tick();
    probe(5'd3, 5'd0);
    chk("t3_x3", rs1_data, 32'h0);
    chk("t3_ret", retired_cnt, 32'd3);
    chk("t3_jmp", jump_cnt, 32'd0);
    chk("t3_halt", {31'b0, halted}, 32'h0);
    tick();
    retire(32'h0DE0_0013, 1'b1, 5'd0, 32'hDEAD);
    tick();
    probe(5'd0, 5'd0);
    chk("t3_x0", rs1_data, 32'h0);
    chk("t3_ret2", retired_cnt, 32'd4);
    tick();

    // 4: ecall display, then pausing ecall
    retire(ECALL, 1'b0, 5'd0, 32'h0);
    alu_res2_in = 32'hCAFE;
    tick();
    probe(5'd0, 5'd0);
    chk("t4_disp", disp_data, 32'hCAFE);
    tick();
    retire(ECALL, 1'b1, 5'd4, 32'd7);
    pause_in = 1'b1; alu_res2_in = 32'hBEEF;
    tick();
    probe(5'd4, 5'd0);
    chk("t4_x4", rs1_data, 32'd7);
    chk("t4_halt", {31'b0, halted}, 32'h1);
    chk("t4_ret", retired_cnt, 32'd6);
    chk("t4_disp2", disp_data, 32'hCAFE);
    tick();
    retire(32'h0090_0213, 1'b1, 5'd4, 32'd9);
    jump_in = 1'b1;
    tick();
    probe(5'd4, 5'd0);
    chk("t4_frozen", rs1_data, 32'd7);
    chk("t4_ret2", retired_cnt, 32'd6);
    chk("t4_jmp", jump_cnt, 32'd0);
    tick();

    // 5: jumps and counter wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    probe(5'd4, 5'd0);
    chk("t5_rst_halt", {31'b0, halted}, 32'h0);
    chk("t5_rst_x4", rs1_data, 32'h0);
    tick();
    for (int k = 0; k < 3; k++) begin
      retire(32'h0080_006F, 1'b1, 5'd1, 32'd100 + 32'(k));
      jump_in = 1'b1;
      tick();
    end
    probe(5'd1, 5'd0);
    chk("t5_jmp", jump_cnt, 32'd3);
    chk("t5_x1", rs1_data, 32'd102);
    tick();
    force dut.retired_q = 32'hFFFF_FFFF;
    ret_bias = 32'hFFFF_FFFF - m_ret;
    #1;
    release dut.retired_q;
    retire(32'h0010_0093, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    chk("t5_preload", retired_cnt, 32'hFFFF_FFFF);
    tick();
    probe(5'd0, 5'd0);
    chk("t5_wrap", retired_cnt, 32'h0);
    tick();

    // 6: same-cycle read of an active write, then reset while halted
    retire(32'h0010_0293, 1'b1, 5'd5, 32'd1);
    tick();
    retire(32'h0090_0293, 1'b1, 5'd5, 32'd9);
    rs1_addr = 5'd5;
    @(negedge clk);
`ifdef WB_BYPASS_EN
    chk("t6_bypass", rs1_data, 32'd9);
`else
    chk("t6_nobypass", rs1_data, 32'd1);
`endif
    tick();
    probe(5'd5, 5'd0);
    chk("t6_x5", rs1_data, 32'd9);
    tick();
    retire(ECALL, 1'b1, 5'd6, 32'd3);
    pause_in = 1'b1; jump_in = 1'b1;
    tick();
    idle();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ret_bias = 32'h0;
    probe(5'd6, 5'd5);
    chk("t6_halt", {31'b0, halted}, 32'h0);
    chk("t6_ret", retired_cnt, 32'h0);
    chk("t6_jmp", jump_cnt, 32'h0);
    tick();

    // Randomized traffic checked by the per-cycle compare process
    for (int c = 0; c < 3000; c++) begin
      int sel;
      rst           = ($urandom_range(0, 249) == 0);
      retire_en     = ($urandom_range(0, 3) != 0);
      sel           = $urandom_range(0, 7);
      instr_in      = (sel == 0) ? 32'h0 : (sel == 1) ? ECALL : $urandom();
      pc_in         = $urandom();
      mem_to_reg_in = $urandom_range(0, 1) == 1;
      half_in       = $urandom_range(0, 1) == 1;
      reg_write_in  = $urandom_range(0, 3) != 0;
      rd_addr_in    = 5'($urandom_range(0, 31));
      alu_res1_in   = $urandom();
      alu_res2_in   = $urandom();
      dmem_out_in   = $urandom();
      jump_in       = $urandom_range(0, 2) == 0;
      pause_in      = $urandom_range(0, 59) == 0;
      rs1_addr      = ($urandom_range(0, 3) == 0) ? rd_addr_in : 5'($urandom_range(0, 31));
      rs2_addr      = 5'($urandom_range(0, 31));
      tick();
    end
    rst = 1'b0;
    idle();
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
